// File: rtl/rf_dual_wb_pkg.sv
// Shared widths, writeback-bus slot layout and the decoded slot type for rf_dual_wb.
// Also provides the WS_TO_RF_BUS_WD and NREG macros used by the top level.
`ifndef RF_DUAL_WB_DEFINES
`define RF_DUAL_WB_DEFINES
`define WS_TO_RF_BUS_WD 140
`define NREG 32
`endif

package rf_dual_wb_pkg;

  localparam int unsigned SLOT_WD   = 70;
  localparam int unsigned WE_BIT    = 37;
  localparam int unsigned WADDR_LSB = 32;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned RAW       = 5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            we;
    logic [RAW-1:0]  waddr;
    logic [XLEN-1:0] wdata;
  } wb_slot_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register in-flight write counters: issue increments, writeback decrements, flush clears.
// Sticky sb_err on saturation or clamp. RF_BYPASS_EN drops busy when the last write retires now.
module rf_scoreboard
  import rf_dual_wb_pkg::*;
#(
  parameter int unsigned NREG = 32,
  parameter int unsigned SB_W = 2,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_flush,
  input  logic                i_is_valid1,
  input  logic                i_is_we1,
  input  logic [AW-1:0]       i_is_dest1,
  input  logic                i_is_valid2,
  input  logic                i_is_we2,
  input  logic [AW-1:0]       i_is_dest2,
  input  logic                i_we1,
  input  logic [AW-1:0]       i_waddr1,
  input  logic                i_we2,
  input  logic [AW-1:0]       i_waddr2,
  input  logic                i_collide,
  input  logic [3:0][AW-1:0]  i_raddr,
  output logic [3:0]          o_busy,
  output logic                o_sb_err
);

  localparam int unsigned CW = SB_W + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << SB_W) - 1);

  logic [SB_W-1:0] r_cnt   [NREG];
  logic [SB_W-1:0] w_cnt_d [NREG];
  logic [CW-1:0]   w_inc   [NREG];
  logic [CW-1:0]   w_dec   [NREG];
  logic [CW-1:0]   w_sum   [NREG];
  logic            w_err_set;
  logic            r_sb_err;

  always_comb begin
    w_err_set = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      w_inc[r]   = '0;
      w_dec[r]   = '0;
      w_sum[r]   = '0;
      w_cnt_d[r] = r_cnt[r];
      if (r != 0) begin
        w_inc[r] = CW'(i_is_valid1 & i_is_we1 & (i_is_dest1 == AW'(r)))
                 + CW'(i_is_valid2 & i_is_we2 & (i_is_dest2 == AW'(r)));
        // A WB same-dest collision retires both instructions even with we1 suppressed.
        w_dec[r] = CW'((i_we1 | i_collide) & (i_waddr1 == AW'(r)))
                 + CW'(i_we2 & (i_waddr2 == AW'(r)));
        w_sum[r] = {1'b0, r_cnt[r]} + w_inc[r];
        if (w_sum[r] < w_dec[r]) begin
          w_cnt_d[r] = '0;
          w_err_set  = 1'b1;
        end else if ((w_sum[r] - w_dec[r]) > CNT_MAX) begin
          w_cnt_d[r] = CNT_MAX[SB_W-1:0];
          w_err_set  = 1'b1;
        end else begin
          w_cnt_d[r] = SB_W'(w_sum[r] - w_dec[r]);
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
      r_sb_err <= 1'b0;
    end else if (i_flush) begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) r_cnt[r] <= w_cnt_d[r];
      if (w_err_set) r_sb_err <= 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      o_busy[k] = (i_raddr[k] != '0) && (r_cnt[i_raddr[k]] != '0);
`ifdef RF_BYPASS_EN
      if ({1'b0, r_cnt[i_raddr[k]]} == w_dec[i_raddr[k]]) o_busy[k] = 1'b0;
`endif
    end
  end

  assign o_sb_err = r_sb_err;

endmodule

// File: rtl/rf_dual_wb.sv
// Dual-write, four-read register file with a pending-write scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data and retirement onto the read ports.
module rf_dual_wb
  import rf_dual_wb_pkg::*;
#(
  parameter int unsigned NREG = `NREG,
  parameter int unsigned SB_W = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [`WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  input  logic [RAW-1:0]              raddr1,
  input  logic [RAW-1:0]              raddr2,
  input  logic [RAW-1:0]              raddr3,
  input  logic [RAW-1:0]              raddr4,
  output logic [XLEN-1:0]             rdata1,
  output logic [XLEN-1:0]             rdata2,
  output logic [XLEN-1:0]             rdata3,
  output logic [XLEN-1:0]             rdata4,
  output logic                        busy1,
  output logic                        busy2,
  output logic                        busy3,
  output logic                        busy4,
  input  logic                        is_valid1,
  input  logic                        is_valid2,
  input  logic                        is_we1,
  input  logic                        is_we2,
  input  logic [RAW-1:0]              is_dest1,
  input  logic [RAW-1:0]              is_dest2,
  input  logic                        flush,
  output logic                        sb_err
);

  wb_slot_t              w_s1, w_s2;
  logic                  w_collide;
  logic [3:0][RAW-1:0]   w_raddr;
  logic [3:0][XLEN-1:0]  w_rdata;
  logic [3:0]            w_busy;
  logic [XLEN-1:0]       r_gpr [NREG];

  function automatic wb_slot_t decode_slot(input logic [SLOT_WD-1:0] s);
    decode_slot.pc    = s[WE_BIT+1 +: XLEN];
    decode_slot.we    = s[WE_BIT];
    decode_slot.waddr = s[WADDR_LSB +: RAW];
    decode_slot.wdata = s[0 +: XLEN];
  endfunction

  assign w_s1      = decode_slot(ws_to_rf_bus[SLOT_WD +: SLOT_WD]);
  assign w_s2      = decode_slot(ws_to_rf_bus[0 +: SLOT_WD]);
  assign w_collide = w_s2.we && (w_s1.waddr == w_s2.waddr) && (w_s1.pc != w_s2.pc);
  assign w_raddr   = {raddr4, raddr3, raddr2, raddr1};

  // Slot2 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_gpr[i] <= '0;
    end else begin
      if (w_s1.we && (w_s1.waddr != '0)) r_gpr[w_s1.waddr] <= w_s1.wdata;
      if (w_s2.we && (w_s2.waddr != '0)) r_gpr[w_s2.waddr] <= w_s2.wdata;
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      w_rdata[k] = (w_raddr[k] == '0) ? '0 : r_gpr[w_raddr[k]];
`ifdef RF_BYPASS_EN
      if (w_raddr[k] != '0) begin
        if (w_s1.we && (w_s1.waddr == w_raddr[k])) w_rdata[k] = w_s1.wdata;
        if (w_s2.we && (w_s2.waddr == w_raddr[k])) w_rdata[k] = w_s2.wdata;
      end
`endif
    end
  end

  rf_scoreboard #(
    .NREG (NREG),
    .SB_W (SB_W)
  ) u_sb (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_flush     (flush),
    .i_is_valid1 (is_valid1),
    .i_is_we1    (is_we1),
    .i_is_dest1  (is_dest1),
    .i_is_valid2 (is_valid2),
    .i_is_we2    (is_we2),
    .i_is_dest2  (is_dest2),
    .i_we1       (w_s1.we),
    .i_waddr1    (w_s1.waddr),
    .i_we2       (w_s2.we),
    .i_waddr2    (w_s2.waddr),
    .i_collide   (w_collide),
    .i_raddr     (w_raddr),
    .o_busy      (w_busy),
    .o_sb_err    (sb_err)
  );

  assign rdata1 = w_rdata[0];
  assign rdata2 = w_rdata[1];
  assign rdata3 = w_rdata[2];
  assign rdata4 = w_rdata[3];
  assign busy1  = w_busy[0];
  assign busy2  = w_busy[1];
  assign busy3  = w_busy[2];
  assign busy4  = w_busy[3];

endmodule

// File: tb/tb_rf_dual_wb.sv
// Directed bench for rf_dual_wb: reset, dual write, collisions, scoreboard, overflow/flush, bypass.
`timescale 1ns/1ps
module tb_rf_dual_wb;

  logic         clk = 1'b0;
  logic         reset;
  logic [139:0] ws_to_rf_bus;
  logic [4:0]   raddr1, raddr2, raddr3, raddr4;
  logic [31:0]  rdata1, rdata2, rdata3, rdata4;
  logic         busy1, busy2, busy3, busy4;
  logic         is_valid1, is_valid2, is_we1, is_we2;
  logic [4:0]   is_dest1, is_dest2;
  logic         flush;
  logic         sb_err;
  int           total = 0;
  int           bad = 0;

  always #5 clk = ~clk;

  rf_dual_wb dut (
    .clk          (clk),
    .reset        (reset),
    .ws_to_rf_bus (ws_to_rf_bus),
    .raddr1       (raddr1),
    .raddr2       (raddr2),
    .raddr3       (raddr3),
    .raddr4       (raddr4),
    .rdata1       (rdata1),
    .rdata2       (rdata2),
    .rdata3       (rdata3),
    .rdata4       (rdata4),
    .busy1        (busy1),
    .busy2        (busy2),
    .busy3        (busy3),
    .busy4        (busy4),
    .is_valid1    (is_valid1),
    .is_valid2    (is_valid2),
    .is_we1       (is_we1),
    .is_we2       (is_we2),
    .is_dest1     (is_dest1),
    .is_dest2     (is_dest2),
    .flush        (flush),
    .sb_err       (sb_err)
  );

  task automatic wb(input logic we1, input logic [4:0] a1, input logic [31:0] d1,
                    input logic we2, input logic [4:0] a2, input logic [31:0] d2,
                    input logic [31:0] p1, input logic [31:0] p2);
    ws_to_rf_bus = {p1, we1, a1, d1, p2, we2, a2, d2};
  endtask

  task automatic iss(input logic v1, input logic [4:0] d1, input logic v2, input logic [4:0] d2);
    is_valid1 = v1; is_we1 = v1; is_dest1 = d1;
    is_valid2 = v2; is_we2 = v2; is_dest2 = d2;
  endtask

  task automatic clr();
    ws_to_rf_bus = '0;
    iss(1'b0, 5'd0, 1'b0, 5'd0);
    flush = 1'b0;
  endtask

  // One clock edge consumes the driven inputs; inputs return to idle afterwards.
  task automatic cyc();
    @(posedge clk);
    #1;
    clr();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clr();
    do_reset();
    for (int k = 0; k < 32; k++) begin
      raddr1 = 5'(k); raddr2 = 5'(k); raddr3 = 5'(k); raddr4 = 5'(k);
      #1;
      total++;
      if ({rdata1, rdata2, rdata3, rdata4, busy1, busy2, busy3, busy4} !== '0) begin
        bad++;
        $display("FAIL reset_read r%0d got=%h/%h/%h/%h busy=%b%b%b%b want=0", k,
                 rdata1, rdata2, rdata3, rdata4, busy1, busy2, busy3, busy4);
      end
    end
    total++;
    if (sb_err !== 1'b0) begin bad++; $display("FAIL reset_sb_err got=%b want=0", sb_err); end
  endtask

  task automatic test_dual_write();
    raddr1 = 5; raddr2 = 6;
    iss(1, 5, 1, 6);
    cyc();
    total++;
    if ({busy1, busy2} !== 2'b11) begin bad++; $display("FAIL issue_busy got=%b%b want=11", busy1, busy2); end
    wb(1, 5, 32'h1111_1111, 1, 6, 32'h2222_2222, 32'h100, 32'h104);
    cyc();
    total++;
    if (rdata1 !== 32'h1111_1111) begin bad++; $display("FAIL dual_wr_r5 got=%h want=11111111", rdata1); end
    total++;
    if (rdata2 !== 32'h2222_2222) begin bad++; $display("FAIL dual_wr_r6 got=%h want=22222222", rdata2); end
    total++;
    if ({busy1, busy2} !== 2'b00) begin bad++; $display("FAIL retire_busy got=%b%b want=00", busy1, busy2); end
    wb(1, 0, 32'hDEAD, 0, 0, 0, 32'h108, 32'h10c);
    raddr1 = 0;
    cyc();
    total++;
    if ({rdata1, busy1} !== 33'd0) begin bad++; $display("FAIL r0_write got=%h busy=%b want=0", rdata1, busy1); end
  endtask

  task automatic test_collision();
    raddr1 = 7;
    iss(1, 7, 1, 7);
    cyc();
    wb(1, 7, 32'hA, 1, 7, 32'hB, 32'h200, 32'h204);
    cyc();
    total++;
    if (rdata1 !== 32'hB) begin bad++; $display("FAIL collision_data got=%h want=0000000b", rdata1); end
    total++;
    if ({busy1, sb_err} !== 2'b00) begin bad++; $display("FAIL collision_sb got=%b%b want=00", busy1, sb_err); end
  endtask

  task automatic test_scoreboard();
    raddr1 = 3;
    iss(1, 3, 1, 3);
    cyc();
    total++;
    if (busy1 !== 1'b1) begin bad++; $display("FAIL sb_cnt2 got=%b want=1", busy1); end
    wb(1, 3, 32'h31, 0, 0, 0, 32'h300, 32'h304);
    cyc();
    total++;
    if (busy1 !== 1'b1) begin bad++; $display("FAIL sb_first_retire got=%b want=1", busy1); end
    wb(0, 0, 0, 1, 3, 32'h32, 32'h308, 32'h30c);
    cyc();
    total++;
    if (busy1 !== 1'b0) begin bad++; $display("FAIL sb_second_retire got=%b want=0", busy1); end
    iss(1, 3, 0, 0);
    cyc();
    iss(1, 3, 0, 0);
    wb(1, 3, 32'h33, 0, 0, 0, 32'h310, 32'h314);
    cyc();
    total++;
    if (busy1 !== 1'b1) begin bad++; $display("FAIL sb_inc_dec_net got=%b want=1", busy1); end
    wb(1, 3, 32'h34, 0, 0, 0, 32'h318, 32'h31c);
    cyc();
    total++;
    if (busy1 !== 1'b0) begin bad++; $display("FAIL sb_drain got=%b want=0", busy1); end
    // WB suppressed we1 on a same-dest pair: still retires two.
    iss(1, 3, 1, 3);
    cyc();
    wb(0, 3, 0, 1, 3, 32'h35, 32'h320, 32'h324);
    cyc();
    total++;
    if ({busy1, sb_err} !== 2'b00) begin bad++; $display("FAIL sb_wb_collide got=%b%b want=00", busy1, sb_err); end
    // Same pc on both slots is not a collision: a single retire.
    iss(1, 3, 0, 0);
    cyc();
    wb(0, 3, 0, 1, 3, 32'h36, 32'h330, 32'h330);
    cyc();
    total++;
    if ({busy1, sb_err} !== 2'b00) begin bad++; $display("FAIL sb_same_pc got=%b%b want=00", busy1, sb_err); end
    total++;
    if (rdata1 !== 32'h36) begin bad++; $display("FAIL sb_same_pc_data got=%h want=00000036", rdata1); end
  endtask

  task automatic test_underflow_reset();
    raddr2 = 12;
    wb(1, 12, 32'h1212, 0, 0, 0, 32'h400, 32'h404);
    cyc();
    total++;
    if ({sb_err, busy2} !== 2'b10) begin bad++; $display("FAIL underflow got=%b%b want=10", sb_err, busy2); end
    total++;
    if (rdata2 !== 32'h1212) begin bad++; $display("FAIL underflow_data got=%h want=00001212", rdata2); end
    reset = 1'b1;
    wb(1, 12, 32'h7777, 0, 0, 0, 32'h408, 32'h40c);
    cyc();
    reset = 1'b0;
    total++;
    if ({sb_err, rdata2} !== 33'd0) begin bad++; $display("FAIL reset_prio got=%b/%h want=0/0", sb_err, rdata2); end
  endtask

  task automatic test_overflow_flush();
    raddr4 = 9;
    iss(1, 9, 1, 9);
    cyc();
    total++;
    if ({sb_err, busy4} !== 2'b01) begin bad++; $display("FAIL ovf_pre got=%b%b want=01", sb_err, busy4); end
    iss(1, 9, 1, 9);
    cyc();
    total++;
    if ({sb_err, busy4} !== 2'b11) begin bad++; $display("FAIL ovf_set got=%b%b want=11", sb_err, busy4); end
    wb(1, 9, 32'h91, 0, 0, 0, 32'h500, 32'h504);
    cyc();
    wb(1, 9, 32'h92, 0, 0, 0, 32'h508, 32'h50c);
    cyc();
    total++;
    if (busy4 !== 1'b1) begin bad++; $display("FAIL ovf_saturated got=%b want=1", busy4); end
    flush = 1'b1;
    iss(1, 9, 0, 0);
    wb(0, 0, 0, 1, 9, 32'h99, 32'h510, 32'h514);
    cyc();
    total++;
    if ({busy4, sb_err} !== 2'b01) begin bad++; $display("FAIL flush got=%b%b want=01", busy4, sb_err); end
    total++;
    if (rdata4 !== 32'h99) begin bad++; $display("FAIL flush_write got=%h want=00000099", rdata4); end
  endtask

  task automatic test_bypass();
    logic [31:0] exp_d;
    logic        exp_b;
    do_reset();
    raddr3 = 4;
    iss(1, 4, 0, 0);
    cyc();
    wb(1, 4, 32'h33, 0, 0, 0, 32'h600, 32'h604);
    cyc();
    iss(1, 4, 0, 0);
    cyc();
    wb(0, 0, 0, 1, 4, 32'h55, 32'h608, 32'h60c);
    #1;
`ifdef RF_BYPASS_EN
    exp_d = 32'h55; exp_b = 1'b0;
`else
    exp_d = 32'h33; exp_b = 1'b1;
`endif
    total++;
    if (rdata3 !== exp_d) begin bad++; $display("FAIL bypass_data got=%h want=%h", rdata3, exp_d); end
    total++;
    if (busy3 !== exp_b) begin bad++; $display("FAIL bypass_busy got=%b want=%b", busy3, exp_b); end
    cyc();
    total++;
    if ({rdata3, busy3, sb_err} !== {32'h55, 2'b00}) begin
      bad++; $display("FAIL post_bypass got=%h/%b/%b want=55/0/0", rdata3, busy3, sb_err);
    end
  endtask

  initial begin
    reset = 1'b1;
    raddr1 = 0; raddr2 = 0; raddr3 = 0; raddr4 = 0;
    clr();
    test_reset();
    test_dual_write();
    test_collision();
    test_scoreboard();
    test_underflow_reset();
    test_overflow_flush();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
